// File: rtl/divider_pkg.sv
// Shared constants and types for the run-time clock-enable divider.
// Imported by the divider core, its controller and the register block.
package divider_pkg;

  localparam int unsigned DIV_W_DFLT   = 8;
  localparam int unsigned DEF_DIV_DFLT = 5;

  // Requested ratio value that is accepted but never stored; answered with cfg_err.
  localparam int unsigned DIV_ZERO_ERR = 0;

  typedef logic [DIV_W_DFLT-1:0] ratio_t;

endpackage : divider_pkg

// File: rtl/divider_core.sv
// Period counter for the clock-enable divider: counts 0..div_cur-1 while run_en
// is high and raises a registered flag in the last count of every period.
module divider_core
  import divider_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DFLT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_en,
  input  logic [DIV_W-1:0] div_cur,
  input  logic [DIV_W-1:0] div_nxt,
  output logic             flag,
  output logic             busy,
  output logic             boundary
);

  localparam logic [DIV_W-1:0] ONE = DIV_W'(1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             busy_q, busy_d;

  assign boundary = busy_q && (cnt_q == div_cur - ONE);

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    cnt_d  = '0;
    flag_d = 1'b0;
    busy_d = 1'b0;
    if (run_en) begin
      busy_d = 1'b1;
      if (busy_q && !boundary) begin
        cnt_d = cnt_q + ONE;
      end
      // The flag for the next cycle must use the ratio that will be in force then.
      flag_d = (cnt_d == div_nxt - ONE);
    end
  end

  // NOTE: state registers take non-blocking assignments only; all decisions live in always_comb.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
      busy_q <= busy_d;
    end
  end

  assign flag = flag_q;
  assign busy = busy_q;

endmodule : divider_core

// File: rtl/divider_ctrl.sv
// Run-time divider controller: accepts new ratios over valid/ready and applies
// them only at a period boundary (or at once when idle), never mid-period.
module divider_ctrl
  import divider_pkg::*;
#(
  parameter int unsigned DIV_W   = DIV_W_DFLT,
  parameter int unsigned DEF_DIV = DEF_DIV_DFLT
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             run_en,
  input  logic             cfg_valid,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_flag,
  output logic [DIV_W-1:0] cur_div,
  output logic             busy
);

  logic [DIV_W-1:0] cur_q, cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             ready_q, ready_d;
  logic             err_q, err_d;
  logic             boundary;
  logic             xfer;
  logic             apply;

  divider_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk      (sys_clk),
    .rst_n    (sys_rst_n),
    .run_en   (run_en),
    .div_cur  (cur_q),
    .div_nxt  (cur_d),
    .flag     (clk_flag),
    .busy     (busy),
    .boundary (boundary)
  );

  assign xfer  = cfg_valid && ready_q;
  // Pending ratio lands at the end of a boundary cycle, or on the next cycle when idle.
  assign apply = pend_vld_q && (!busy || boundary);

  always_comb begin
    cur_d      = cur_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    ready_d    = ready_q;
    err_d      = 1'b0;
    if (apply) begin
      cur_d      = pend_q;
      pend_vld_d = 1'b0;
      ready_d    = 1'b1;
    end
    if (xfer) begin
      if (cfg_div == DIV_W'(DIV_ZERO_ERR)) begin
        err_d = 1'b1;
      end else begin
        pend_d     = cfg_div;
        pend_vld_d = 1'b1;
        ready_d    = 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      cur_q      <= DIV_W'(DEF_DIV);
      // NOTE: pend_q is reset as well, though pend_vld_q qualifies it, so X can never reach cur_div.
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      ready_q    <= 1'b1;
      err_q      <= 1'b0;
    end else begin
      cur_q      <= cur_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      ready_q    <= ready_d;
      err_q      <= err_d;
    end
  end

  assign cur_div   = cur_q;
  assign cfg_ready = ready_q;
  assign cfg_err   = err_q;

endmodule : divider_ctrl
